// File: rtl/lightsaber_pwm.sv
// Three-channel PWM LED driver for the lightsaber blade: ignite/retract brightness
// ramp, with colour and brightness latched only at frame boundaries.
module lightsaber_pwm #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Ri,
  input  logic [7:0] Gi,
  input  logic [7:0] Bi,
  input  logic       en,
  output logic       r_pwm,
  output logic       g_pwm,
  output logic       b_pwm,
  output logic       frame_start,
  output logic       lit,
  output logic       busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]    STEP9    = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    IGNITE  = 2'd1,
    ON      = 2'd2,
    RETRACT = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic          tick;
  logic          fb;
  logic [7:0]    bright;
  logic [7:0]    bright_nxt;
  logic [7:0]    bright_up;
  logic [7:0]    bright_dn;
  logic [8:0]    sum9;
  logic [8:0]    diff9;
  logic [7:0]    duty_r;
  logic [7:0]    duty_g;
  logic [7:0]    duty_b;

  // Colour scaled by brightness; bright+1 lets full brightness pass the colour unchanged.
  function automatic logic [7:0] scale(input logic [7:0] x, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(x) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction

  assign tick = (pre == PRE_LAST);
  assign fb   = tick && (cnt == 8'hFF);

  // Saturating ramp steps; bit 8 flags overflow on add and borrow on subtract.
  assign sum9      = {1'b0, bright} + STEP9;
  assign diff9     = {1'b0, bright} - STEP9;
  assign bright_up = sum9[8]  ? 8'hFF : sum9[7:0];
  assign bright_dn = diff9[8] ? 8'h00 : diff9[7:0];

  always_comb begin
    state_nxt  = state;
    bright_nxt = bright;
    case (state)
      OFF: begin
        if (en) begin
          state_nxt  = IGNITE;
          bright_nxt = bright_up;
        end else begin
          bright_nxt = 8'h00;
        end
      end
      IGNITE: begin
        if (!en) begin
          state_nxt  = RETRACT;
          bright_nxt = bright_dn;
        end else begin
          bright_nxt = bright_up;
          if (bright_up == 8'hFF) state_nxt = ON;
        end
      end
      ON: begin
        if (!en) begin
          state_nxt  = RETRACT;
          bright_nxt = bright_dn;
        end else begin
          bright_nxt = 8'hFF;
        end
      end
      RETRACT: begin
        if (en) begin
          state_nxt  = IGNITE;
          bright_nxt = bright_up;
        end else begin
          bright_nxt = bright_dn;
          if (bright_dn == 8'h00) state_nxt = OFF;
        end
      end
      default: begin
        state_nxt  = OFF;
        bright_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      cnt         <= 8'h00;
      state       <= OFF;
      bright      <= 8'h00;
      duty_r      <= 8'h00;
      duty_g      <= 8'h00;
      duty_b      <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      pre         <= tick ? '0 : pre + PW'(1);
      frame_start <= fb;
      if (tick) cnt <= cnt + 8'd1;
      // Shadow duties use the state/brightness of the frame that is ending.
      if (fb) begin
        duty_r <= (state == OFF) ? 8'h00 : scale(Ri, bright);
        duty_g <= (state == OFF) ? 8'h00 : scale(Gi, bright);
        duty_b <= (state == OFF) ? 8'h00 : scale(Bi, bright);
        state  <= state_nxt;
        bright <= bright_nxt;
      end
    end
  end

  assign r_pwm = (cnt < duty_r);
  assign g_pwm = (cnt < duty_g);
  assign b_pwm = (cnt < duty_b);
  assign lit   = (state == ON);
  assign busy  = (state == IGNITE) || (state == RETRACT);

endmodule

// File: tb/tb_lightsaber_pwm.sv
// Bench for lightsaber_pwm: frame-level integer model compared every cycle on two
// instances (PRESCALE 1 and 2), plus hand-computed frame high-time expectations.
module tb_lightsaber_pwm;

  localparam int STEP = 64;
  localparam int M_OFF = 0, M_IGN = 1, M_ON = 2, M_RET = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [7:0] Ri, Gi, Bi;
  logic r0, g0, b0, fs0, lit0, busy0;
  logic r1, g1, b1, fs1, lit1, busy1;

  lightsaber_pwm #(.PRESCALE(1), .RAMP_STEP(STEP)) u0 (
    .clk(clk), .rst(rst), .Ri(Ri), .Gi(Gi), .Bi(Bi), .en(en),
    .r_pwm(r0), .g_pwm(g0), .b_pwm(b0), .frame_start(fs0), .lit(lit0), .busy(busy0)
  );

  lightsaber_pwm #(.PRESCALE(2), .RAMP_STEP(STEP)) u1 (
    .clk(clk), .rst(rst), .Ri(Ri), .Gi(Gi), .Bi(Bi), .en(en),
    .r_pwm(r1), .g_pwm(g1), .b_pwm(b1), .frame_start(fs1), .lit(lit1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: cycle position within the frame, brightness and duties as integers.
  int m_cyc[2];
  int m_st[2];
  int m_br[2];
  int m_d[2][3];
  bit m_fs[2];
  bit m_valid = 1'b0;

  function automatic int pv(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int up(input int b);
    return (b + STEP > 255) ? 255 : b + STEP;
  endfunction

  function automatic int dn(input int b);
    return (b - STEP < 0) ? 0 : b - STEP;
  endfunction

  task automatic model_edge(input int i);
    int f;
    int col[3];
    if (rst) begin
      m_cyc[i] = 0; m_st[i] = M_OFF; m_br[i] = 0; m_fs[i] = 1'b0;
      for (int c = 0; c < 3; c++) m_d[i][c] = 0;
    end else begin
      f = 256 * pv(i);
      m_fs[i] = ((m_cyc[i] % f) == f - 1);
      if (m_fs[i]) begin
        col[0] = int'(Ri); col[1] = int'(Gi); col[2] = int'(Bi);
        for (int c = 0; c < 3; c++)
          m_d[i][c] = (m_st[i] == M_OFF) ? 0 : (col[c] * (m_br[i] + 1)) / 256;
        case (m_st[i])
          M_OFF: if (en) begin m_st[i] = M_IGN; m_br[i] = up(m_br[i]); end
                 else m_br[i] = 0;
          M_IGN: if (!en) begin m_st[i] = M_RET; m_br[i] = dn(m_br[i]); end
                 else begin m_br[i] = up(m_br[i]); if (m_br[i] == 255) m_st[i] = M_ON; end
          M_ON:  if (!en) begin m_st[i] = M_RET; m_br[i] = dn(m_br[i]); end
                 else m_br[i] = 255;
          default: if (en) begin m_st[i] = M_IGN; m_br[i] = up(m_br[i]); end
                   else begin m_br[i] = dn(m_br[i]); if (m_br[i] == 0) m_st[i] = M_OFF; end
        endcase
      end
      m_cyc[i]++;
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_valid = 1'b1;
    model_edge(0);
    model_edge(1);
  end

  function automatic logic [5:0] model_out(input int i);
    int cnt;
    cnt = (m_cyc[i] % (256 * pv(i))) / pv(i);
    return {cnt < m_d[i][0], cnt < m_d[i][1], cnt < m_d[i][2], m_fs[i],
            m_st[i] == M_ON, (m_st[i] == M_IGN) || (m_st[i] == M_RET)};
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_outputs_u0", 32'({r0, g0, b0, fs0, lit0, busy0}), 32'(model_out(0)));
      check("cycle_outputs_u1", 32'({r1, g1, b1, fs1, lit1, busy1}), 32'(model_out(1)));
    end
  end

  task automatic wait_fs(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((i == 0) ? fs0 : fs1) && n < 3000);
    if (!((i == 0) ? fs0 : fs1)) check("frame_start_timeout", 32'(n), 32'd0);
  endtask

  // Sample one full frame of u0, starting at its frame_start cycle.
  task automatic measure0(input int chg_at, input logic [7:0] new_g,
                          output int nr, output int ng, output int nb,
                          output logic lit_s, output logic busy_s);
    int n;
    nr = 0; ng = 0; nb = 0;
    wait_fs(0, n);
    lit_s  = lit0;
    busy_s = busy0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      if (k == chg_at) Gi = new_g;
      nr += int'(r0); ng += int'(g0); nb += int'(b0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nr, ng, nb, high, run, best;
    logic ls, bs;

    rst = 1'b1; en = 1'b0; Ri = 8'd255; Gi = 8'd128; Bi = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs_u0", 32'({r0, g0, b0, fs0, lit0, busy0}), 32'd0);
    check("reset_outputs_u1", 32'({r1, g1, b1, fs1, lit1, busy1}), 32'd0);
    rst = 1'b0;

    wait_fs(0, n); check("first_frame_start", 32'(n), 32'd256);
    wait_fs(0, n); check("second_frame_gap",  32'(n), 32'd256);
    wait_fs(0, n); check("third_frame_gap",   32'(n), 32'd256);

    // Ignite: next boundary leaves OFF, duties follow one frame later.
    en = 1'b1;
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("ign_f0_r", 32'(nr), 32'd0);
    check("ign_f0_busy", 32'(bs), 32'd1);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("ign_f1_r", 32'(nr), 32'd64);
    check("ign_f1_g", 32'(ng), 32'd32);
    check("ign_f1_busy", 32'(bs), 32'd1);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("ign_f2_busy", 32'(bs), 32'd1);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("ign_f3_lit", 32'(ls), 32'd1);
    check("ign_f3_busy", 32'(bs), 32'd0);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("on_r", 32'(nr), 32'd255);
    check("on_g", 32'(ng), 32'd128);
    check("on_b", 32'(nb), 32'd0);

    // Mid-frame colour change only lands after the next boundary.
    measure0(100, 8'd16, nr, ng, nb, ls, bs);
    check("midframe_g_old", 32'(ng), 32'd128);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("midframe_g_new", 32'(ng), 32'd16);

    // Reset at cnt=50 while ON.
    wait_fs(0, n);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midon_reset_u0", 32'({r0, g0, b0, fs0, lit0, busy0}), 32'd0);
    check("midon_reset_u1", 32'({r1, g1, b1, fs1, lit1, busy1}), 32'd0);
    rst = 1'b0;

    // Ramp restarts, then retract while bright=128.
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("restart_f0_r", 32'(nr), 32'd0);
    check("restart_f0_busy", 32'(bs), 32'd1);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("restart_f1_r", 32'(nr), 32'd64);
    en = 1'b0;
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("retract_f0_r", 32'(nr), 32'd128);
    check("retract_f0_busy", 32'(bs), 32'd1);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("retract_f1_r", 32'(nr), 32'd64);
    check("retract_f1_busy", 32'(bs), 32'd0);
    check("retract_f1_lit", 32'(ls), 32'd0);
    measure0(-1, 8'd0, nr, ng, nb, ls, bs);
    check("retract_off_r", 32'(nr), 32'd0);

    // PRESCALE=2 instance fully ON with Ri=128.
    Ri = 8'd128; en = 1'b1;
    repeat (7) wait_fs(1, n);
    wait_fs(1, n);
    high = 0; run = 0; best = 0;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (fs1) check("ps2_early_frame_start", 32'(k), 32'd512);
      end
      if (r1) begin high++; run++; end else run = 0;
      if (run > best) best = run;
    end
    @(negedge clk);
    check("ps2_frame_len", 32'(fs1), 32'd1);
    check("ps2_r_high", 32'(high), 32'd256);
    check("ps2_r_run", 32'(best), 32'd256);

    // Randomized colours, ignite requests and occasional resets against the model.
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(63) == 0) Ri = 8'($urandom);
      if ($urandom_range(63) == 0) Gi = 8'($urandom);
      if ($urandom_range(63) == 0) Bi = 8'($urandom);
      if ($urandom_range(399) == 0) en = ~en;
      if ($urandom_range(4999) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
